// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches the reset vector,
// splits two-byte instructions, and handles stall and branch redirect.
module fetch_unit #(
  parameter int          AW       = 8,
  parameter logic [3:0]  LONG_OP  = 4'hC,
  parameter logic [AW-1:0] VEC_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] imem_addr,
  input  logic [7:0]    imem_data,
  output logic [7:0]    ir_new,
  output logic          sf1_out,
  output logic          ld,
  output logic          flush,
  output logic [AW-1:0] pc_next
);

  typedef enum logic [1:0] {
    S_VEC,
    S_OP,
    S_IMM
  } state_t;

  state_t          state;
  logic [AW-1:0]   pc;
  logic [AW-1:0]   vec_pc;
  logic            active;
  logic            is_long;

  // Vector byte widened or narrowed to PC width.
  if (AW > 8) begin : g_wide
    assign vec_pc = {{(AW-8){1'b0}}, imem_data};
  end else begin : g_narrow
    assign vec_pc = imem_data[AW-1:0];
  end

  assign imem_addr = pc;
  assign ir_new    = imem_data;
  assign pc_next   = pc + 1'b1;
  assign is_long   = (imem_data[7:4] == LONG_OP);

  // Output strobes decoded from the current state and control inputs.
  always_comb begin
    active  = (state != S_VEC);
    ld      = active & ~stall & ~redirect;
    flush   = active & redirect;
    sf1_out = (state == S_IMM);
  end

  // PC and state update: vector fetch, then redirect > stall > advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_VEC;
      pc    <= VEC_ADDR;
    end else begin
      unique case (1'b1)
        !active: begin
          pc    <= vec_pc;
          state <= S_OP;
        end
        active && redirect: begin
          pc    <= redirect_pc;
          state <= S_OP;
        end
        active && !redirect && stall: begin
          pc    <= pc;
          state <= state;
        end
        active && !redirect && !stall: begin
          pc    <= pc_next;
          if (state == S_OP && is_long)
            state <= S_IMM;
          else
            state <= S_OP;
        end
        default: begin
          pc    <= pc;
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit.
// Memory model is a byte array read combinationally at imem_addr.
module tb_fetch_unit;

  logic       clk;
  logic       rst;
  logic       stall;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] ir_new;
  logic       sf1_out;
  logic       ld;
  logic       flush;
  logic [7:0] pc_next;

  logic [7:0] mem [256];

  int checks;
  int errors;

  typedef struct packed {
    logic       st;
    logic       rd;
    logic [7:0] rpc;
    logic [7:0] addr;
    logic [7:0] ir;
    logic       ld;
    logic       sf1;
    logic       fl;
  } vec_t;

  vec_t tbl [15];

  fetch_unit #(
    .AW(8),
    .LONG_OP(4'hC),
    .VEC_ADDR(8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .ir_new(ir_new),
    .sf1_out(sf1_out),
    .ld(ld),
    .flush(flush),
    .pc_next(pc_next)
  );

  assign imem_data = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [7:0] a,
                         input logic l,
                         input logic s,
                         input logic f);
    logic [7:0] pn;
    pn = a + 8'h01;
    chk({tag, " addr"}, imem_addr, a);
    chk({tag, " ld"}, {7'd0, ld}, {7'd0, l});
    chk({tag, " sf1"}, {7'd0, sf1_out}, {7'd0, s});
    chk({tag, " flush"}, {7'd0, flush}, {7'd0, f});
    chk({tag, " pc_next"}, pc_next, pn);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h10;
    mem[8'h10] = 8'h01;

    // Reset state and first-fetch latency with mem[10]=01.
    @(negedge clk);
    chk_all("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_all("t1 c1", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_all("t1 c2", 8'h10, 1'b1, 1'b0, 1'b0);
    chk("t1 ir", ir_new, 8'h01);

    // Program for the table run.
    mem[8'h10] = 8'hC5;
    mem[8'h11] = 8'h3A;
    mem[8'h12] = 8'h02;
    mem[8'h13] = 8'hC7;
    mem[8'h40] = 8'h5A;
    mem[8'hFF] = 8'hC0;
    mem[8'h01] = 8'h03;
    mem[8'h02] = 8'hC9;

    //          st    rd    rpc    addr   ir     ld    sf1   fl
    tbl[0]  = '{1'b1, 1'b1, 8'h80, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 8'h10, 8'hC5, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 8'h11, 8'h3A, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'h00, 8'h11, 8'h3A, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'h00, 8'h11, 8'h3A, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 8'h11, 8'h3A, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 8'h12, 8'h02, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 8'h13, 8'hC7, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 8'h40, 8'h14, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 8'h40, 8'h5A, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'hFF, 8'h41, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 8'hFF, 8'hC0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h10, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 8'h01, 8'h03, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 8'h02, 8'hC9, 1'b1, 1'b0, 1'b0};

    // Re-enter reset so the table starts from a vector fetch.
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      string tag;
      tag         = $sformatf("v%0d", i);
      stall       = tbl[i].st;
      redirect    = tbl[i].rd;
      redirect_pc = tbl[i].rpc;
      @(negedge clk);
      chk_all(tag, tbl[i].addr, tbl[i].ld, tbl[i].sf1, tbl[i].fl);
      chk({tag, " ir"}, ir_new, tbl[i].ir);
      @(posedge clk); #1;
    end

    // Asynchronous reset while waiting on an immediate.
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    @(negedge clk);
    chk_all("t6 imm", 8'h03, 1'b1, 1'b1, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    chk_all("t6 rst", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("t6 hold", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk_all("t6 vec", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_all("t6 op", 8'h10, 1'b1, 1'b0, 1'b0);
    chk("t6 ir", ir_new, 8'hC5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
